cheby_coeff_store: RTL and testbench
====================================

// Module: cheby_coeff_store
// PURPOSE
//  Writer/holder side of the Chebyshev coefficient table used by the BF16 exp evaluator.
//  Accepts a streamed load of BF16 coefficients over a valid/ready port and stores them as NSEG segments x NCOEF terms.
//  Serves per-segment coefficient reads, all NCOEF terms in parallel, to the evaluator pipeline.
//  Replaces the evaluator's hard-coded constant include with a runtime-loadable table.
// PARAMETERS
//  DW     16   coefficient width (BF16)
//  NSEG   128  number of segments (segment index = int(x)+64)
//  NCOEF  4    coefficients per segment (T0..T3)
//  IDXW   7    segment index width, clog2(NSEG)
// PORTS
//  clk          in   1         clock, all state on posedge
//  rst          in   1         asynchronous, active-high reset
//  load_start   in   1         pulse: begin (or restart) a full table load
//  wr_valid     in   1         load beat valid
//  wr_data      in   DW        load beat: one BF16 coefficient
//  wr_ready     out  1         load beat accepted when wr_valid&wr_ready
//  table_valid  out  1         full table loaded and readable
//  load_count   out  IDXW+3    beats accepted in current/last load
//  rd_en        in   1         read request
//  rd_idx       in   IDXW      segment to read
//  rd_valid     out  1         read data valid (1 cycle after rd_en)
//  rd_err       out  1         with rd_valid: read while table not valid
//  rd_coef      out  NCOEF*DW  {T3,T2,T1,T0}; T0 in [DW-1:0]
// BEHAVIOUR
//  Reset: state=IDLE, wr_ready=0, table_valid=0, load_count=0, rd_valid=0, rd_err=0, rd_coef=0.
//   Storage array is not cleared; table_valid gates its use.
//  FSM states: IDLE, LOAD, DONE.
//   IDLE/DONE --load_start--> LOAD: clears seg_ptr, coef_ptr and load_count; table_valid<=0.
//   LOAD --last beat accepted--> DONE, table_valid<=1.
//   LOAD --load_start--> LOAD: restart; pointers and count cleared; beats already written are stale.
//  wr_ready is 1 exactly while state==LOAD, as a registered output; it is 0 in the cycle load_start is sampled.
//  Beat order: segment-major, coefficient-minor. Beat n writes seg=n/NCOEF, term=n%NCOEF.
//   coef_ptr wraps NCOEF-1 -> 0 and increments seg_ptr.
//   The beat with seg_ptr=NSEG-1 and coef_ptr=NCOEF-1 is the last beat.
//  load_count increments per accepted beat and saturates at NSEG*NCOEF. It holds its value in DONE.
//  load_start and wr_valid in the same cycle: load_start wins and the beat is not accepted.
//  Read port:
//   Latency 1: rd_valid<=rd_en, registered.
//   If table_valid=1: rd_coef<=store[rd_idx] and rd_err<=0.
//   If table_valid=0: rd_coef<=0 and rd_err<=rd_en.
//   table_valid is sampled in the same cycle as rd_en.
//   rd_idx >= NSEG clamps to NSEG-1. This only applies when NSEG is not a power of 2.
//   With rd_en=0, rd_valid<=0 and rd_coef holds.
//   Back-to-back reads are allowed every cycle.
//  A read in the same cycle as the last load beat returns rd_err=1, because table_valid is not yet set.
//  Reset mid-load: returns to IDLE with table_valid=0. A full reload is required.
//  No arithmetic is performed on coefficients; they are stored bit-exact.
// STRUCTURE
//  Shared package cheby_pkg holds:
//   - the DW/NSEG/NCOEF/IDXW defaults
//   - the state enum {IDLE,LOAD,DONE}
//   - a coef_vec_t typedef for the NCOEF*DW read bundle
//  The same package is used by the evaluator.
//  One sub-module: cheby_coeff_bank. It is a 1W/1R synchronous RAM, NSEG deep and DW wide.
//   NCOEF instances are used, one per term.
//   The write enable for term k is (beat accepted && coef_ptr==k).
//  The top level holds the FSM, pointers, count and the read error/gating logic.
// TESTING
//  1. Reset -> all outputs 0. Read idx 5 -> rd_valid=1, rd_err=1, rd_coef=0 next cycle.
//  2. Load 512 beats, beat n = 16'h3F80+n, with wr_valid held high.
//     -> table_valid=1 after the last beat, load_count=512.
//     -> Read idx 3 returns {16'h3F8F,16'h3F8E,16'h3F8D,16'h3F8C}.
//  3. Random wr_valid gaps (~50%) during the load.
//     -> Contents identical to test 2, and no beat is accepted while wr_ready=0.
//  4. load_start after 100 beats, then a full 512-beat load of a new pattern.
//     -> load_count restarts at 0, table_valid stays 0 until done, all entries hold the new pattern.
//  5. rst asserted mid-load (beat 200) -> IDLE, wr_ready=0, table_valid=0. Reads give rd_err=1.
//  6. After a load, read every cycle with idx 0..127 ascending.
//     -> rd_valid continuous, each rd_coef matches the model with 1-cycle latency.
//     -> load_start during the reads makes subsequent reads rd_err=1.

Source files
------------

// File: rtl/cheby_pkg.sv
// Shared definitions for the Chebyshev coefficient table and the BF16 exp evaluator.
package cheby_pkg;
   localparam int DW     = 16;
   localparam int NSEG   = 128;
   localparam int NCOEF  = 4;
   localparam int IDXW   = $clog2(NSEG);
   localparam int CNTW   = IDXW + 3;
   localparam int NBEATS = NSEG * NCOEF;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   typedef logic [NCOEF*DW-1:0] coef_vec_t;
endpackage

// File: rtl/cheby_coeff_store_if.sv
// Load stream and segment read port of the coefficient store.
interface cheby_coeff_store_if;
   import cheby_pkg::*;

   logic            load_start;
   logic            wr_valid;
   logic [DW-1:0]   wr_data;
   logic            wr_ready;
   logic            table_valid;
   logic [CNTW-1:0] load_count;
   logic            rd_en;
   logic [IDXW-1:0] rd_idx;
   logic            rd_valid;
   logic            rd_err;
   coef_vec_t       rd_coef;

   modport master (
      output load_start, wr_valid, wr_data, rd_en, rd_idx,
      input  wr_ready, table_valid, load_count, rd_valid, rd_err, rd_coef
   );

   modport slave (
      input  load_start, wr_valid, wr_data, rd_en, rd_idx,
      output wr_ready, table_valid, load_count, rd_valid, rd_err, rd_coef
   );
endinterface

// File: rtl/cheby_coeff_bank.sv
// 1W/1R synchronous RAM holding one Chebyshev term for every segment.
module cheby_coeff_bank
   import cheby_pkg::*;
#(
   parameter int DEPTH = NSEG,
   parameter int WIDTH = DW,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: array and read register carry no reset so they map onto block RAM; table_valid gates their use.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/cheby_coeff_store.sv
// Runtime-loadable Chebyshev coefficient table: streamed segment-major load,
// one-cycle parallel read of all terms of a segment.
module cheby_coeff_store
   import cheby_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cheby_coeff_store_if.slave bus
);
   localparam int CPW = $clog2(NCOEF);

   state_t          state;
   logic [IDXW-1:0] seg_ptr;
   logic [CPW-1:0]  coef_ptr;
   logic            beat;
   logic            last_beat;
   logic            rd_zero;
   logic [IDXW-1:0] rd_addr;
   logic [DW-1:0]   bank_q [NCOEF];
   coef_vec_t       rd_vec;

   // load_start takes precedence over a beat presented in the same cycle
   assign beat      = bus.wr_valid && bus.wr_ready && !bus.load_start;
   assign last_beat = (seg_ptr == IDXW'(NSEG - 1)) && (coef_ptr == CPW'(NCOEF - 1));

   generate
      if (NSEG == (1 << IDXW)) begin : g_no_clamp
         assign rd_addr = bus.rd_idx;
      end else begin : g_clamp
         assign rd_addr = (bus.rd_idx >= IDXW'(NSEG)) ? IDXW'(NSEG - 1) : bus.rd_idx;
      end
   endgenerate

   for (genvar k = 0; k < NCOEF; k++) begin : g_bank
      cheby_coeff_bank u_bank (
         .clk   (clk),
         .we    (beat && (coef_ptr == CPW'(k))),
         .waddr (seg_ptr),
         .wdata (bus.wr_data),
         .re    (bus.rd_en),
         .raddr (rd_addr),
         .rdata (bank_q[k])
      );
      assign rd_vec[k*DW +: DW] = rd_zero ? '0 : bank_q[k];
   end

   assign bus.rd_coef = rd_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         bus.wr_ready    <= 1'b0;
         bus.table_valid <= 1'b0;
         bus.load_count  <= '0;
         seg_ptr         <= '0;
         coef_ptr        <= '0;
      end else if (bus.load_start) begin
         state           <= LOAD;
         bus.wr_ready    <= 1'b1;
         bus.table_valid <= 1'b0;
         bus.load_count  <= '0;
         seg_ptr         <= '0;
         coef_ptr        <= '0;
      end else if (state == LOAD && beat) begin
         if (bus.load_count != CNTW'(NBEATS)) bus.load_count <= bus.load_count + 1'b1;
         if (last_beat) begin
            state           <= DONE;
            bus.wr_ready    <= 1'b0;
            bus.table_valid <= 1'b1;
         end else if (coef_ptr == CPW'(NCOEF - 1)) begin
            coef_ptr <= '0;
            seg_ptr  <= seg_ptr + 1'b1;
         end else begin
            coef_ptr <= coef_ptr + 1'b1;
         end
      end
   end

   // rd_zero masks the bank outputs after a read issued against an invalid table
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rd_valid <= 1'b0;
         bus.rd_err   <= 1'b0;
         rd_zero      <= 1'b1;
      end else begin
         bus.rd_valid <= bus.rd_en;
         bus.rd_err   <= bus.rd_en && !bus.table_valid;
         if (bus.rd_en) rd_zero <= !bus.table_valid;
      end
   end
endmodule

// File: tb/tb_cheby_coeff_store.sv
// Randomized self-checking bench for cheby_coeff_store against a beat-indexed table model.
module tb_cheby_coeff_store;
   import cheby_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cheby_coeff_store_if bus ();

   cheby_coeff_store dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the table as a flat list of beats, beat n = segment n/NCOEF, term n%NCOEF.
   logic [DW-1:0] m_mem [NBEATS];
   bit            m_loading;
   bit            m_valid;
   int            m_n;
   bit            m_rv;
   bit            m_rerr;
   logic [63:0]   m_coef;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] seg_word(input int seg);
      logic [63:0] v;
      v = '0;
      for (int t = 0; t < NCOEF; t++) v[t*DW +: DW] = m_mem[seg*NCOEF + t];
      return v;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".wr_ready"},    64'(bus.wr_ready),    64'(m_loading));
      check({tag, ".table_valid"}, 64'(bus.table_valid), 64'(m_valid));
      check({tag, ".load_count"},  64'(bus.load_count),  64'(m_n));
      check({tag, ".rd_valid"},    64'(bus.rd_valid),    64'(m_rv));
      check({tag, ".rd_err"},      64'(bus.rd_err),      64'(m_rerr));
      check({tag, ".rd_coef"},     64'(bus.rd_coef),     m_coef);
   endtask

   // One clock: drive inputs, advance the model, observe #1 after the edge.
   task automatic tick(input string tag, input bit ls, input bit wv, input logic [DW-1:0] wd,
                       input bit re, input logic [IDXW-1:0] ri);
      bit acc;
      bus.load_start = ls;
      bus.wr_valid   = wv;
      bus.wr_data    = wd;
      bus.rd_en      = re;
      bus.rd_idx     = ri;
      acc    = m_loading && wv && !ls;
      m_rv   = re;
      m_rerr = re && !m_valid;
      if (re) m_coef = m_valid ? seg_word(int'(ri)) : 64'h0;
      if (ls) begin
         m_loading = 1;
         m_valid   = 0;
         m_n       = 0;
      end else if (acc) begin
         m_mem[m_n] = wd;
         m_n++;
         if (m_n == NBEATS) begin
            m_loading = 0;
            m_valid   = 1;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      bus.load_start = 0;
      bus.wr_valid   = 0;
      bus.wr_data    = '0;
      bus.rd_en      = 0;
      bus.rd_idx     = '0;
      rst = 1'b1;
      #2;
      m_loading = 0;
      m_valid   = 0;
      m_n       = 0;
      m_rv      = 0;
      m_rerr    = 0;
      m_coef    = '0;
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Drive beats until the model says the load completed or stop_at beats were accepted.
   // mode 0: data 3F80+n, mode 1: random data; gap_pct = chance of wr_valid=0 per cycle.
   task automatic run_load(input string tag, input int mode, input int gap_pct, input int stop_at);
      logic [DW-1:0] d;
      for (int c = 0; c < 6000 && m_loading && m_n < stop_at; c++) begin
         d = (mode == 0) ? DW'(16'h3F80 + m_n) : DW'($urandom);
         tick(tag, 0, ($urandom_range(99) >= gap_pct), d, $urandom_range(1), IDXW'($urandom));
      end
      check({tag, ".bound"}, 64'(m_n >= stop_at || !m_loading), 64'd1);
   endtask

   task automatic read_all_formula(input string tag);
      logic [63:0] e;
      for (int i = 0; i < NSEG; i++) begin
         tick(tag, 0, 0, '0, 1, IDXW'(i));
         for (int t = 0; t < NCOEF; t++) e[t*DW +: DW] = DW'(16'h3F80 + i*NCOEF + t);
         check({tag, ".formula"}, 64'(bus.rd_coef), e);
      end
   endtask

   initial begin
      bus.load_start = 0;
      bus.wr_valid   = 0;
      bus.wr_data    = '0;
      bus.rd_en      = 0;
      bus.rd_idx     = '0;

      // 1: reset state and read before any load
      do_reset("t1.reset");
      check("t1.all_zero", {bus.wr_ready, bus.table_valid, bus.load_count, bus.rd_valid, bus.rd_err, bus.rd_coef}, '0);
      tick("t1.read5", 0, 0, '0, 1, 7'd5);
      check("t1.read5.err", {bus.rd_valid, bus.rd_err, bus.rd_coef}, {2'b11, 64'h0});

      // 2: back-to-back load of 3F80+n, beat offered alongside load_start is dropped
      tick("t2.start", 1, 1, 16'hDEAD, 0, '0);
      check("t2.ready_after_start", 64'(bus.wr_ready), 64'd1);
      run_load("t2.load", 0, 0, NBEATS);
      check("t2.table_valid", 64'(bus.table_valid), 64'd1);
      check("t2.load_count", 64'(bus.load_count), 64'd512);
      tick("t2.read3", 0, 0, '0, 1, 7'd3);
      check("t2.read3.val", 64'(bus.rd_coef), 64'h3F8F_3F8E_3F8D_3F8C);
      tick("t2.idle", 0, 1, 16'hBEEF, 0, '0);
      check("t2.hold_count", 64'(bus.load_count), 64'd512);

      // 3: ~50% gaps on wr_valid, same pattern
      tick("t3.start", 1, 0, '0, 0, '0);
      run_load("t3.load", 0, 50, NBEATS);
      read_all_formula("t3.read");

      // 4: restart after 100 beats, then a full random-pattern load
      tick("t4.start", 1, 0, '0, 0, '0);
      run_load("t4.part", 1, 30, 100);
      check("t4.part_count", 64'(bus.load_count), 64'd100);
      tick("t4.restart", 1, 1, 16'h1234, 1, 7'd9);
      check("t4.restart_count", 64'(bus.load_count), 64'd0);
      run_load("t4.load", 1, 30, NBEATS);
      for (int i = 0; i < NSEG; i++) tick("t4.read", 0, 0, '0, 1, IDXW'(i));

      // 5: reset at beat 200
      tick("t5.start", 1, 0, '0, 0, '0);
      run_load("t5.load", 1, 0, 200);
      do_reset("t5.reset");
      check("t5.ready", {bus.wr_ready, bus.table_valid}, 64'd0);
      tick("t5.read", 0, 0, '0, 1, 7'd17);
      check("t5.read.err", 64'(bus.rd_err), 64'd1);

      // 6: streaming reads 0..127, load_start in the middle
      tick("t6.start", 1, 0, '0, 0, '0);
      run_load("t6.load", 1, 20, NBEATS);
      for (int i = 0; i < NSEG; i++) begin
         tick("t6.read", (i == 64), 0, '0, 1, IDXW'(i));
         if (i > 64) check("t6.err_after_restart", 64'(bus.rd_err), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
